// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between the WB stage / multi-cycle unit and the
// register-file write arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              pend_hit;
    logic              stall_out;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_din;

    modport slave (
        input  wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data, rs_addr, rt_addr,
        output mc_ready, pend_hit, stall_out, rf_write, rf_waddr, rf_din
    );

    modport master (
        output wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data, rs_addr, rt_addr,
        input  mc_ready, pend_hit, stall_out, rf_write, rf_waddr, rf_din
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, multi-cycle results queue in a
// small FIFO and drain into idle cycles, with a starvation-driven forced freeze.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              rf_write_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_din_q;

    logic              empty, full, stall, mc_ready;
    logic              grant_fifo, grant_wb, push, pop;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [FIFO_DEPTH-1:0] entry_vld;
    logic              rs_hit, rt_hit;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign stall      = (starve_q == STV_W'(STARVE_MAX)) && !empty;
    assign grant_fifo = !empty && (stall || !bus.wb_valid);
    assign grant_wb   = !stall && bus.wb_valid;
    assign mc_ready   = !full && !rst_i;
    // $zero results complete the handshake but never occupy a slot
    assign push       = bus.mc_valid && mc_ready && (bus.mc_addr != '0);
    assign pop        = grant_fifo;

    always_comb begin
        win_valid = 1'b0;
        win_addr  = bus.wb_addr;
        win_data  = bus.wb_data;
        if (grant_fifo) begin
            win_valid = 1'b1;
            win_addr  = fifo_addr_q[rd_ptr_q];
            win_data  = fifo_data_q[rd_ptr_q];
        end else if (grant_wb) begin
            win_valid = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push && pop)
            count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (grant_wb && starve_q != STV_W'(STARVE_MAX))
            starve_d = starve_q + STV_W'(1);
    end

    // An entry is live when its distance from the read pointer is below the count
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_vld
        logic [PTR_W-1:0] offs;
        assign offs         = PTR_W'(i) - rd_ptr_q;
        assign entry_vld[i] = (CNT_W'(offs) < count_q);
    end

    always_comb begin
        rs_hit = rf_write_q && (rf_waddr_q == bus.rs_addr);
        rt_hit = rf_write_q && (rf_waddr_q == bus.rt_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i] && fifo_addr_q[i] == bus.rs_addr) rs_hit = 1'b1;
            if (entry_vld[i] && fifo_addr_q[i] == bus.rt_addr) rt_hit = 1'b1;
        end
        rs_hit = rs_hit && (bus.rs_addr != '0);
        rt_hit = rt_hit && (bus.rt_addr != '0);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.mc_addr;
            fifo_data_q[wr_ptr_q] <= bus.mc_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_din_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            starve_q <= starve_d;
            if (win_valid) begin
                rf_write_q <= (win_addr != '0);
                rf_waddr_q <= win_addr;
                rf_din_q   <= win_data;
            end else begin
                rf_write_q <= 1'b0;
            end
        end
    end

    assign bus.mc_ready  = mc_ready;
    assign bus.stall_out = stall;
    assign bus.pend_hit  = rs_hit || rt_hit;
    assign bus.rf_write  = rf_write_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_din    = rf_din_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 2, SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] mq_addr [$];
    logic [DW-1:0] mq_data [$];
    int            m_starve = 0;
    logic          m_write  = 1'b0;
    logic [AW-1:0] m_waddr  = '0;
    logic [DW-1:0] m_din    = '0;

    function automatic logic m_stall();
        return (m_starve == SMAX) && (mq_addr.size() > 0);
    endfunction

    function automatic logic m_ready();
        return !rst && (mq_addr.size() < DEPTH);
    endfunction

    function automatic logic m_hit1(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        if (m_write && m_waddr == a) return 1'b1;
        foreach (mq_addr[i]) if (mq_addr[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_pend();
        return m_hit1(bus.rs_addr) || m_hit1(bus.rt_addr);
    endfunction

    // Advance the reference model by one cycle using the current inputs, then clock.
    task automatic step();
        logic stl, rdy, wasne, winf, winw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        stl   = m_stall();
        rdy   = m_ready();
        wasne = (mq_addr.size() > 0);
        if (rst) begin
            mq_addr.delete(); mq_data.delete();
            m_starve = 0; m_write = 1'b0; m_waddr = '0; m_din = '0;
        end else begin
            winf = wasne && (stl || !bus.wb_valid);
            winw = !stl && bus.wb_valid;
            if (winf) begin
                ha = mq_addr.pop_front(); hd = mq_data.pop_front();
                m_write = (ha != '0); m_waddr = ha; m_din = hd; m_starve = 0;
            end else if (winw) begin
                m_write = (bus.wb_addr != '0); m_waddr = bus.wb_addr; m_din = bus.wb_data;
                if (wasne && m_starve < SMAX) m_starve++;
            end else begin
                m_write = 1'b0;
            end
            if (!wasne) m_starve = 0;
            if (bus.mc_valid && rdy && bus.mc_addr != '0) begin
                mq_addr.push_back(bus.mc_addr);
                mq_data.push_back(bus.mc_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.mc_valid = 1'b0; bus.mc_addr = '0; bus.mc_data = '0;
        bus.rs_addr  = '0;   bus.rt_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd4; bus.mc_data = 32'h1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h2;
        bus.rs_addr  = 5'd4;
        #1;
        checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.mc_ready); end
        step(); step();
        checks++; if (bus.rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got %b exp 0", bus.rf_write); end
        checks++; if (bus.rf_waddr !== 5'd0 || bus.rf_din !== 32'd0) begin errors++; $display("FAIL reset_rf_regs got %0d/%h exp 0/0", bus.rf_waddr, bus.rf_din); end
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_out); end
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", bus.pend_hit); end
        checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %b exp 0", bus.mc_ready); end
        rst = 1'b0;
        idle_inputs();
        step();
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.mc_ready); end
        checks++; if (bus.rf_write !== 1'b0) begin errors++; $display("FAIL reset_no_write got %b exp 0", bus.rf_write); end
    endtask

    task automatic test_wb_only();
        idle_inputs();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_00AA;
        step();
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_din !== 32'hAA)
            begin errors++; $display("FAIL wb_write got %b/%0d/%h exp 1/3/aa", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        step();
        checks++; if (bus.rf_write !== 1'b0) begin errors++; $display("FAIL wb_zero got %b exp 0", bus.rf_write); end
        idle_inputs();
        step();
    endtask

    task automatic test_idle_drain();
        idle_inputs();
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd5; bus.mc_data = 32'h1234; bus.rs_addr = 5'd5;
        #1;
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", bus.mc_ready); end
        step();
        bus.mc_valid = 1'b0;
        #1;
        checks++; if (bus.rf_write !== 1'b0) begin errors++; $display("FAIL drain_early got %b exp 0", bus.rf_write); end
        checks++; if (bus.pend_hit !== 1'b1) begin errors++; $display("FAIL drain_pend_q got %b exp 1", bus.pend_hit); end
        step();
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_din !== 32'h1234)
            begin errors++; $display("FAIL drain_write got %b/%0d/%h exp 1/5/1234", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        checks++; if (bus.pend_hit !== 1'b1) begin errors++; $display("FAIL drain_pend_rf got %b exp 1", bus.pend_hit); end
        step();
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL drain_pend_clear got %b exp 0", bus.pend_hit); end
        idle_inputs();
    endtask

    task automatic test_full_fifo();
        logic [DW-1:0] obs [$];
        logic [DW-1:0] tags [3];
        int  n;
        bit  accepted;
        tags[0] = 32'hC0DE_0001; tags[1] = 32'hC0DE_0002; tags[2] = 32'hC0DE_0003;
        idle_inputs();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd1;
        for (int k = 0; k < 2; k++) begin
            bus.wb_data  = 32'h0000_0100 + 32'(k);
            bus.mc_valid = 1'b1; bus.mc_addr = 5'(10 + k); bus.mc_data = tags[k];
            #1;
            checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d_ready got %b exp 1", k, bus.mc_ready); end
            step();
        end
        bus.mc_addr = 5'd12; bus.mc_data = tags[2];
        #1;
        checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.mc_ready); end
        accepted = 1'b0;
        n = 0;
        while (n < 30) begin
            if (!m_stall()) bus.wb_data = 32'h0000_0200 + 32'(n);
            if (accepted) bus.mc_valid = 1'b0;
            if (n == 15) bus.wb_valid = 1'b0;
            #1;
            checks++; if (bus.mc_ready !== m_ready()) begin errors++; $display("FAIL full_loop_ready got %b exp %b", bus.mc_ready, m_ready()); end
            if (bus.mc_valid && m_ready()) accepted = 1'b1;
            step();
            checks++; if (bus.rf_write !== m_write) begin errors++; $display("FAIL full_loop_write got %b exp %b", bus.rf_write, m_write); end
            if (bus.rf_write && bus.rf_din[31:16] == 16'hC0DE) obs.push_back(bus.rf_din);
            n++;
        end
        checks++; if (!accepted) begin errors++; $display("FAIL full_third_accept got 0 exp 1"); end
        checks++; if (obs.size() != 3) begin errors++; $display("FAIL full_retire_count got %0d exp 3", obs.size()); end
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            checks++; if (obs[k] !== tags[k]) begin errors++; $display("FAIL full_order%0d got %h exp %h", k, obs[k], tags[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [DW-1:0] wd;
        idle_inputs();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h1;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd20; bus.mc_data = 32'hC0DE_0020;
        step();
        bus.mc_valid = 1'b0;
        for (int k = 0; k < SMAX; k++) begin
            wd = 32'h100 + 32'(k);
            bus.wb_data = wd;
            #1;
            checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL starve_early%0d got %b exp 0", k, bus.stall_out); end
            step();
            checks++; if (bus.rf_din !== wd || bus.rf_waddr !== 5'd8) begin errors++; $display("FAIL starve_wb%0d got %h exp %h", k, bus.rf_din, wd); end
        end
        bus.wb_addr = 5'd9; bus.wb_data = 32'h200;
        #1;
        checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL starve_stall got %b exp 1", bus.stall_out); end
        step();
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd20 || bus.rf_din !== 32'hC0DE_0020)
            begin errors++; $display("FAIL starve_mc_write got %b/%0d/%h exp 1/20/c0de0020", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL starve_clear got %b exp 0", bus.stall_out); end
        step();
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_din !== 32'h200)
            begin errors++; $display("FAIL starve_held_wb got %b/%0d/%h exp 1/9/200", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        idle_inputs();
        step();
    endtask

    task automatic test_simul_push_pop();
        idle_inputs();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h77;
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd7; bus.mc_data = 32'hC0DE_0007;
        step();
        bus.wb_valid = 1'b0;
        bus.mc_addr = 5'd9; bus.mc_data = 32'hC0DE_0009; bus.rs_addr = 5'd9;
        #1;
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got %b exp 1", bus.mc_ready); end
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL pp_pend_pre got %b exp 0", bus.pend_hit); end
        step();
        bus.mc_valid = 1'b0;
        #1;
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_din !== 32'hC0DE_0007)
            begin errors++; $display("FAIL pp_head got %b/%0d/%h exp 1/7/c0de0007", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        checks++; if (bus.pend_hit !== 1'b1) begin errors++; $display("FAIL pp_new_queued got %b exp 1", bus.pend_hit); end
        step();
        checks++; if (bus.rf_write !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_din !== 32'hC0DE_0009)
            begin errors++; $display("FAIL pp_next got %b/%0d/%h exp 1/9/c0de0009", bus.rf_write, bus.rf_waddr, bus.rf_din); end
        step();
        checks++; if (bus.pend_hit !== 1'b0 || bus.rf_write !== 1'b0) begin errors++; $display("FAIL pp_empty got %b/%b exp 0/0", bus.pend_hit, bus.rf_write); end
        idle_inputs();
    endtask

    task automatic test_mc_zero();
        idle_inputs();
        bus.mc_valid = 1'b1; bus.mc_addr = 5'd0; bus.mc_data = 32'hFFFF;
        #1;
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", bus.mc_ready); end
        step();
        bus.mc_valid = 1'b0;
        step();
        checks++; if (bus.rf_write !== 1'b0) begin errors++; $display("FAIL zero_not_queued got %b exp 0", bus.rf_write); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!m_stall()) begin
                bus.wb_valid = ($urandom_range(0, 9) < 6);
                bus.wb_addr  = AW'($urandom_range(0, 7));
                bus.wb_data  = $urandom;
            end
            bus.mc_valid = $urandom_range(0, 1);
            bus.mc_addr  = AW'($urandom_range(0, 7));
            bus.mc_data  = $urandom;
            bus.rs_addr  = AW'($urandom_range(0, 7));
            bus.rt_addr  = AW'($urandom_range(0, 7));
            #1;
            checks++; if (bus.mc_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, bus.mc_ready, m_ready()); end
            checks++; if (bus.stall_out !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, bus.stall_out, m_stall()); end
            checks++; if (bus.pend_hit !== m_pend()) begin errors++; $display("FAIL rnd_pend cyc %0d got %b exp %b", n, bus.pend_hit, m_pend()); end
            step();
            checks++; if (bus.rf_write !== m_write) begin errors++; $display("FAIL rnd_write cyc %0d got %b exp %b", n, bus.rf_write, m_write); end
            if (m_write) begin
                checks++; if (bus.rf_waddr !== m_waddr || bus.rf_din !== m_din)
                    begin errors++; $display("FAIL rnd_data cyc %0d got %0d/%h exp %0d/%h", n, bus.rf_waddr, bus.rf_din, m_waddr, m_din); end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_wb_only();
        test_idle_drain();
        test_full_fifo();
        test_starvation();
        test_simul_push_pop();
        test_mc_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
